// File: rtl/mips_multiciclo_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module mips_multiciclo_control #(
    parameter int INSTR_CNT_W     = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    output logic                   PCEn,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUCtl,
    output logic [1:0]             PCSource,
    output logic                   Illegal,
    output logic [3:0]             State,
    output logic [INSTR_CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13,
        S_UNUSED14 = 4'd14,
        S_UNUSED15 = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t                 state_q, state_d;
    logic [INSTR_CNT_W-1:0] count_q, count_d;
    logic                   pc_write, pc_write_cond, retire;
    logic                   funct_ok;
    logic [2:0]             funct_alu;

    // Map an R-type Funct field to an ALU operation; unsupported codes flag illegal.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUCtl        = ALU_ADD;
        PCSource      = 2'b00;
        Illegal       = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUCtl  = funct_alu;
                state_d = funct_ok ? S_RTYPE_WB : S_ILLEGAL;
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUCtl        = ALU_SUB;
                PCSource      = 2'b01;
                pc_write_cond = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            // A trapping FSM parks here until reset; otherwise the flag is a one-cycle pulse.
            S_ILLEGAL: begin
                Illegal = 1'b1;
                state_d = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign count_d    = retire ? count_q + INSTR_CNT_W'(1) : count_q;
    assign PCEn       = pc_write | (pc_write_cond & Zero);
    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mips_multiciclo_control.sv
// Randomized bench for the multi-cycle MIPS control FSM: each instruction is expanded
// into its expected per-cycle output table and compared against the DUT every cycle.
module tb_mips_multiciclo_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  Opcode = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUCtl;
    logic        Illegal;
    logic [3:0]  State;
    logic [31:0] InstrCount;
    logic [16:0] dutv;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] v;
        bit          zdep;
        bit          retire;
    } step_t;
    step_t q[$];

    mips_multiciclo_control #(.INSTR_CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .PCSource(PCSource),
        .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    assign dutv = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUCtl, PCSource, Illegal};

    function automatic logic [16:0] V(input bit pcen, iord, mr, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, input logic [2:0] alu,
                                      input logic [1:0] pcs, input bit ill);
        return {pcen, iord, mr, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [16:0] v, input bit zdep, input bit ret);
        step_t s;
        s.st = st; s.v = v; s.zdep = zdep; s.retire = ret;
        q.push_back(s);
    endtask

    // Expected per-cycle behaviour of one instruction, straight from the instruction tables.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        logic [16:0] ill_v;
        logic [2:0]  alu;
        bit          ok;
        ill_v = V(0,0,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 1);
        push(4'd1, V(1,0,1,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0), 0, 0);
        push(4'd2, V(0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0), 0, 0);
        ok = 1;
        case (op)
            6'b100011: begin
                push(4'd3, V(0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0), 0, 0);
                push(4'd4, V(0,1,1,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0), 0, 0);
                push(4'd5, V(0,0,0,0,0,0,1,1,0, 2'b00, 3'b010, 2'b00, 0), 0, 1);
            end
            6'b101011: begin
                push(4'd3, V(0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0), 0, 0);
                push(4'd6, V(0,1,0,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0), 0, 1);
            end
            6'b000000: begin
                case (fn)
                    6'h20: alu = 3'b010;
                    6'h22: alu = 3'b110;
                    6'h24: alu = 3'b000;
                    6'h25: alu = 3'b001;
                    6'h2A: alu = 3'b111;
                    default: begin alu = 3'b010; ok = 0; end
                endcase
                push(4'd7, V(0,0,0,0,0,0,0,0,1, 2'b00, alu, 2'b00, 0), 0, 0);
                if (ok) push(4'd8, V(0,0,0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 0), 0, 1);
            end
            6'b001000: begin
                push(4'd9,  V(0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0), 0, 0);
                push(4'd10, V(0,0,0,0,0,0,0,1,0, 2'b00, 3'b010, 2'b00, 0), 0, 1);
            end
            6'b000100: push(4'd11, V(0,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0), 1, 1);
            6'b000010: push(4'd12, V(1,0,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 0), 0, 1);
            default: ok = 0;
        endcase
        if (!ok) repeat (20) push(4'd13, ill_v, 0, 0);
    endtask

    task automatic step_check(input int zsel);
        step_t       s;
        logic [16:0] expv;
        @(negedge clk);
        s = q.pop_front();
        Zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        #1;
        expv = s.v;
        if (s.zdep) expv[16] = Zero;
        chk("state", 32'(State), 32'(s.st));
        chk("outputs", 32'(dutv), 32'(expv));
        chk("count", InstrCount, exp_count);
        chk("rw_excl", 32'(RegWrite & (MemWrite | IRWrite)), 32'd0);
        if (s.retire) exp_count++;
    endtask

    task automatic do_reset();
        logic [16:0] init_v;
        init_v = V(0,0,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0);
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("rst_async_state", 32'(State), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 32'(State), 32'd0);
            chk("rst_outputs", 32'(dutv), 32'(init_v));
            chk("rst_count", InstrCount, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("init_state", 32'(State), 32'd0);
        chk("init_outputs", 32'(dutv), 32'(init_v));
        chk("init_count", InstrCount, 32'd0);
        exp_count = 32'd0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel,
                             output int ncyc);
        bit trapped;
        plan(op, fn);
        Opcode = op;
        Funct  = fn;
        ncyc = 0;
        trapped = 0;
        while (q.size() > 0) begin
            if (q[0].st == 4'd13) trapped = 1;
            step_check(zsel);
            ncyc++;
        end
        if (trapped) do_reset();
    endtask

    task automatic lit_count(input logic [31:0] exp);
        @(posedge clk); #1;
        chk("count_literal", InstrCount, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [5:0] op, fn;
        logic [5:0] rfn [5];
        rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h2A;

        do_reset();
        run_instr(6'b100011, 6'h00, 2, n); chk("lat_lw", n, 5);
        lit_count(32'd1);
        run_instr(6'b000000, 6'h22, 2, n); chk("lat_sub", n, 4);
        run_instr(6'b000000, 6'h2A, 2, n); chk("lat_slt", n, 4);
        run_instr(6'b000100, 6'h00, 1, n); chk("lat_beq_taken", n, 3);
        run_instr(6'b000100, 6'h00, 0, n); chk("lat_beq_not", n, 3);
        lit_count(32'd5);
        run_instr(6'b101011, 6'h00, 2, n); chk("lat_sw", n, 4);
        run_instr(6'b001000, 6'h00, 2, n); chk("lat_addi", n, 4);
        run_instr(6'b000010, 6'h00, 2, n); chk("lat_j", n, 3);
        lit_count(32'd8);
        run_instr(6'b111111, 6'h00, 2, n); chk("illegal_op_cycles", n, 22);
        run_instr(6'b000000, 6'h3F, 2, n); chk("illegal_funct_cycles", n, 23);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 19);
            fn = 6'($urandom);
            case (r)
                0, 1, 2:          op = 6'b100011;
                3, 4:             op = 6'b101011;
                5, 6, 7, 8, 9:    begin op = 6'b000000; fn = rfn[$urandom_range(0, 4)]; end
                10, 11:           op = 6'b001000;
                12, 13, 14:       op = 6'b000100;
                15, 16:           op = 6'b000010;
                17:               op = 6'b111111;
                18:               op = 6'b000000;
                default:          op = 6'($urandom);
            endcase
            run_instr(op, fn, 2, n);
        end

        // Abort a lw asynchronously while it is in the memory-read state.
        run_instr(6'b000010, 6'h00, 2, n);
        plan(6'b100011, 6'h00);
        Opcode = 6'b100011;
        Funct  = 6'h00;
        repeat (4) step_check(2);
        q.delete();
        #2 rst = 1'b1;
        #1;
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_regwrite", 32'(RegWrite), 32'd0);
        chk("abort_count", InstrCount, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_regwrite", 32'(RegWrite), 32'd0);
            chk("abort_hold_state", 32'(State), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_init_state", 32'(State), 32'd0);
        exp_count = 32'd0;
        run_instr(6'b100011, 6'h00, 2, n); chk("lat_lw_after_abort", n, 5);
        lit_count(32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
